// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the forwarding/hazard controller.
//   fwd_sel_t    - 2-bit EX operand-mux select
//   dest_info_t  - destination info tracked per shadow pipeline stage
//   dest_match() - "this stage writes register r" (never true for x0)
package fwd_pkg;

  localparam logic [1:0] FWD_ID_EX  = 2'b00;
  localparam logic [1:0] FWD_WB     = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [4:0] REG_X0     = 5'd0;

  typedef logic [1:0] fwd_sel_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } dest_info_t;

  function automatic logic dest_match(input dest_info_t d, input logic [4:0] r);
    return d.regwrite && (d.rd != REG_X0) && (d.rd == r);
  endfunction

endpackage

// File: rtl/fwd_shadow_stage.sv
// fwd_shadow_stage: one stage of the destination-info shadow pipeline.
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-low reset (clears stage)
//   bubble_i - load an all-zero bubble instead of d_i
//   d_i      - incoming destination info
//   q_o      - registered destination info
module fwd_shadow_stage
  import fwd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bubble_i,
  input  dest_info_t d_i,
  output dest_info_t q_o
);

  dest_info_t stage_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        stage_q <= '0;
    else if (bubble_i) stage_q <= '0;
    else               stage_q <= d_i;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: forwarding-select and load-use hazard controller for the
// 5-stage core. Selects are computed while the consumer sits in ID and
// registered into EX; the load-use stall is combinational from ID inputs.
// Optional feature macro: FWD_STALL_CNT_EN (adds stall_cnt_o).
//   clk_i, rst_i          - clock / async active-low reset
//   id_valid_i            - ID holds a real instruction
//   id_rs1_i, id_rs2_i    - ID source registers
//   id_use_rs1_i/rs2_i    - ID instruction reads rs1 / rs2
//   id_rd_i               - ID destination register
//   id_regwrite_i         - ID instruction writes rd
//   id_memread_i          - ID instruction is a load
//   flush_i               - ID instruction squashed
//   stall_o               - load-use stall request
//   forward_a_o/_b_o      - registered EX operand selects
//   stall_cnt_o           - stall cycle counter (FWD_STALL_CNT_EN only)
module forward_ctrl
  import fwd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_regwrite_i,
  input  logic       id_memread_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  dest_info_t id_info;
  dest_info_t ex_q;
  dest_info_t mem_q;
  dest_info_t unused_wb_q;  // WB depth is tracked but not consumed by the selects
  logic       hazard;
  logic       ex_bubble;
  fwd_sel_t   fwd_a_d, fwd_a_q;
  fwd_sel_t   fwd_b_d, fwd_b_q;

  assign id_info = '{rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};

  fwd_shadow_stage u_ex (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bubble_i(ex_bubble),
    .d_i     (id_info),
    .q_o     (ex_q)
  );

  fwd_shadow_stage u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bubble_i(1'b0),
    .d_i     (ex_q),
    .q_o     (mem_q)
  );

  fwd_shadow_stage u_wb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bubble_i(1'b0),
    .d_i     (mem_q),
    .q_o     (unused_wb_q)
  );

  always_comb begin
    hazard = id_valid_i && ex_q.memread && (ex_q.rd != REG_X0) &&
             ((id_use_rs1_i && (ex_q.rd == id_rs1_i)) ||
              (id_use_rs2_i && (ex_q.rd == id_rs2_i)));
    stall_o   = hazard && !flush_i;
    ex_bubble = !id_valid_i || flush_i || stall_o;
  end

  // EX match checked first so the most recent producer wins.
  always_comb begin
    fwd_a_d = FWD_ID_EX;
    fwd_b_d = FWD_ID_EX;
    if (!ex_bubble) begin
      if (id_use_rs1_i && dest_match(ex_q, id_rs1_i))       fwd_a_d = FWD_EX_MEM;
      else if (id_use_rs1_i && dest_match(mem_q, id_rs1_i)) fwd_a_d = FWD_WB;
      if (id_use_rs2_i && dest_match(ex_q, id_rs2_i))       fwd_b_d = FWD_EX_MEM;
      else if (id_use_rs2_i && dest_match(mem_q, id_rs2_i)) fwd_b_d = FWD_WB;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fwd_a_q <= FWD_ID_EX;
      fwd_b_q <= FWD_ID_EX;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign forward_a_o = fwd_a_q;
  assign forward_b_o = fwd_b_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       stall_cnt_q <= '0;
    else if (stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic       id_use_rs1_i, id_use_rs2_i;
  logic       id_regwrite_i, id_memread_i, flush_i;
  logic       stall_o;
  logic [1:0] forward_a_o, forward_b_o;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  forward_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .id_rd_i      (id_rd_i),
    .id_regwrite_i(id_regwrite_i),
    .id_memread_i (id_memread_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .forward_a_o  (forward_a_o),
    .forward_b_o  (forward_b_o)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one instruction in ID.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid_i    = v;
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_use_rs1_i  = u1;
    id_use_rs2_i  = u2;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #11;
    chk("reset_fa", {30'd0, forward_a_o}, 32'd0);
    chk("reset_fb", {30'd0, forward_b_o}, 32'd0);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
`ifdef FWD_STALL_CNT_EN
    chk("reset_cnt", stall_cnt_o, 32'd0);
`endif
    rst_i = 1'b1;
    tick();

    // EX-distance forward: add x5 then consumer rs1=x5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
    drive(1, 5, 3, 1, 1, 0, 0, 0, 0);
    chk("exfwd_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("exfwd_fa", {30'd0, forward_a_o}, 32'h2);
    chk("exfwd_fb", {30'd0, forward_b_o}, 32'h0);

    // MEM-distance forward: x6 writer, independent x8, consumer rs2=x6
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0); tick();
    drive(1, 1, 6, 1, 1, 0, 0, 0, 0); tick();
    chk("memfwd_fb", {30'd0, forward_b_o}, 32'h1);
    chk("memfwd_fa", {30'd0, forward_a_o}, 32'h0);

    // Priority: two writers of x7, consumer reads x7 on both ports
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); tick();
    drive(1, 7, 7, 1, 1, 0, 0, 0, 0); tick();
    chk("prio_fa", {30'd0, forward_a_o}, 32'h2);
    chk("prio_fb", {30'd0, forward_b_o}, 32'h2);

    // Load-use: lw x9, consumer rs2=x9 held through the stall
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0); tick();
    drive(1, 2, 9, 1, 1, 10, 1, 0, 0);
    chk("lu_stall1", {31'd0, stall_o}, 32'd1);
`ifdef FWD_STALL_CNT_EN
    chk("lu_cnt0", stall_cnt_o, 32'd0);
`endif
    tick();
    chk("lu_bubble_fb", {30'd0, forward_b_o}, 32'h0);
    chk("lu_bubble_fa", {30'd0, forward_a_o}, 32'h0);
    chk("lu_stall2", {31'd0, stall_o}, 32'd0);
`ifdef FWD_STALL_CNT_EN
    chk("lu_cnt1", stall_cnt_o, 32'd1);
`endif
    tick();
    chk("lu_cons_fb", {30'd0, forward_b_o}, 32'h1);
`ifdef FWD_STALL_CNT_EN
    chk("lu_cnt_hold", stall_cnt_o, 32'd1);
`endif

    // x0: load to x0 then consumer of x0 on both ports
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("x0_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("x0_fa", {30'd0, forward_a_o}, 32'h0);
    chk("x0_fb", {30'd0, forward_b_o}, 32'h0);

    // Flush beats load-use stall; ex gets a bubble
    drive(1, 0, 0, 0, 0, 11, 1, 1, 0); tick();
    drive(1, 11, 0, 1, 0, 12, 1, 0, 1);
    chk("fl_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("fl_fa", {30'd0, forward_a_o}, 32'h0);
    chk("fl_fb", {30'd0, forward_b_o}, 32'h0);
    // x12 was flushed (no forward); lw x11 now in MEM
    drive(1, 12, 11, 1, 1, 0, 0, 0, 0);
    chk("fl_next_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("fl_next_fa", {30'd0, forward_a_o}, 32'h0);
    chk("fl_next_fb", {30'd0, forward_b_o}, 32'h1);

    // Asynchronous reset mid-stream with live forward and pending stall
    drive(1, 0, 0, 0, 0, 13, 1, 0, 0); tick();
    drive(1, 13, 0, 1, 0, 14, 1, 1, 0); tick();
    chk("mid_pre_fa", {30'd0, forward_a_o}, 32'h2);
    drive(1, 0, 14, 0, 1, 0, 0, 0, 0);
    chk("mid_pre_stall", {31'd0, stall_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_fa", {30'd0, forward_a_o}, 32'h0);
    chk("mid_rst_fb", {30'd0, forward_b_o}, 32'h0);
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
`ifdef FWD_STALL_CNT_EN
    chk("mid_rst_cnt", stall_cnt_o, 32'd0);
`endif
    tick();
    rst_i = 1'b1;
    #1;
    chk("post_rst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("post_rst_fb", {30'd0, forward_b_o}, 32'h0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
